// File: rtl/nf_out_merge_avlstrm_pkg.sv
// ============================================================================
// nf_out_merge_avlstrm_pkg
// Shared types and constants for the non-fast-pattern output merge.
// Revision: 1.0
// ============================================================================
`default_nettype none

package nf_out_merge_avlstrm_pkg;

    // Merge arbiter states: free to arbitrate, or locked to one input mid-packet
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } merge_state_t;

    // Statistics register offsets, consumed by a parent-level stats packer
    localparam logic [7:0] REG_NF_MERGE_PKT0  = 8'h00;
    localparam logic [7:0] REG_NF_MERGE_PKT1  = 8'h04;
    localparam logic [7:0] REG_NF_MERGE_ERR   = 8'h08;
    localparam logic [7:0] REG_NF_MERGE_STALL = 8'h0C;

    // Skid payload = data + empty + sop + eop + src
    function automatic int merge_payload_w(input int dw);
        return dw + $clog2(dw / 8) + 3;
    endfunction

endpackage

`default_nettype wire

// File: rtl/avlstrm_skid_buf.sv
// ============================================================================
// avlstrm_skid_buf
// Two-entry registered skid buffer. Output valid comes straight from the
// occupancy register, and input ready only from occupancy, so neither side
// sees a combinational path from the other side's handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module avlstrm_skid_buf
    import nf_out_merge_avlstrm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_payload_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_payload_o
);

    logic [1:0]   cnt_q, cnt_d;
    logic [W-1:0] e0_q, e0_d;
    logic [W-1:0] e1_q, e1_d;
    logic         push;
    logic         pop;

    assign in_ready_o    = (cnt_q != 2'd2);
    assign out_valid_o   = (cnt_q != 2'd0);
    assign out_payload_o = e0_q;
    assign push          = in_valid_i & in_ready_o;
    assign pop           = out_valid_o & out_ready_i;

    // Next occupancy and entry contents; entry 0 is always the head
    always_comb begin
        cnt_d = cnt_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = in_payload_i;
                else               e1_d = in_payload_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            // Push with pop only happens at occupancy 1: the new beat becomes head
            2'b11:   e0_d = in_payload_i;
            default: ;
        endcase
    end

    // Buffer state registers, flushed by reset
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/nf_out_merge_avlstrm.sv
// ============================================================================
// nf_out_merge_avlstrm
// Packet-atomic 2:1 round-robin merge of the no-check (in0) and checked (in1)
// packet streams into one registered output stream with a source tag and
// per-input statistics. Optional macro NF_MERGE_STALL_CNT_EN adds a counter
// of mid-packet starvation cycles (stats_stall_o).
// Revision: 1.0
// ============================================================================
`default_nettype none

module nf_out_merge_avlstrm
    import nf_out_merge_avlstrm_pkg::*;
#(
    parameter int DW = 512,
    parameter int CW = 32
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [DW-1:0]           in0_data_i,
    input  logic                    in0_valid_i,
    output logic                    in0_ready_o,
    input  logic                    in0_sop_i,
    input  logic                    in0_eop_i,
    input  logic [$clog2(DW/8)-1:0] in0_empty_i,
    input  logic [DW-1:0]           in1_data_i,
    input  logic                    in1_valid_i,
    output logic                    in1_ready_o,
    input  logic                    in1_sop_i,
    input  logic                    in1_eop_i,
    input  logic [$clog2(DW/8)-1:0] in1_empty_i,
    output logic [DW-1:0]           out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    out_sop_o,
    output logic                    out_eop_o,
    output logic [$clog2(DW/8)-1:0] out_empty_o,
    output logic                    out_src_o,
    output logic [CW-1:0]           stats_pkt0_o,
    output logic [CW-1:0]           stats_pkt1_o,
    output logic [CW-1:0]           stats_err_o
`ifdef NF_MERGE_STALL_CNT_EN
    ,
    output logic [CW-1:0]           stats_stall_o
`endif
);

    localparam int EW = $clog2(DW / 8);
    localparam int PW = merge_payload_w(DW);

    merge_state_t  state_q, state_d;
    logic          rr_last_q, rr_last_d;
    logic          run_q;
    logic [CW-1:0] pkt0_q, pkt0_d;
    logic [CW-1:0] pkt1_q, pkt1_d;
    logic [CW-1:0] err_q, err_d;

    logic          free;
    logic          cand0, cand1;
    logic          gnt0, gnt1;
    logic          drop0, drop1;
    logic          push0, push1;
    logic          err0, err1;
    logic [PW-1:0] skid_in;
    logic [PW-1:0] skid_out;

    assign cand0 = in0_valid_i & in0_sop_i;
    assign cand1 = in1_valid_i & in1_sop_i;

    // Grant selection: round-robin between sop candidates in IDLE, fixed while locked.
    // Non-sop beats seen in IDLE are framing errors and are swallowed.
    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        drop0 = 1'b0;
        drop1 = 1'b0;
        case (state_q)
            IDLE: begin
                if (cand0 && cand1) begin
                    gnt0 = rr_last_q;
                    gnt1 = !rr_last_q;
                end else begin
                    gnt0 = cand0;
                    gnt1 = cand1;
                end
                drop0 = in0_valid_i & ~in0_sop_i;
                drop1 = in1_valid_i & ~in1_sop_i;
            end
            LOCK0:   gnt0 = 1'b1;
            LOCK1:   gnt1 = 1'b1;
            default: ;
        endcase
    end

    // run_q holds ready low until the first clock after reset release
    assign in0_ready_o = run_q & ((gnt0 & free) | drop0);
    assign in1_ready_o = run_q & ((gnt1 & free) | drop1);
    assign push0       = run_q & in0_valid_i & gnt0 & free;
    assign push1       = run_q & in1_valid_i & gnt1 & free;
    assign err0        = run_q & drop0;
    assign err1        = run_q & drop1;

    assign skid_in = push1 ? {1'b1, in1_sop_i, in1_eop_i, in1_empty_i, in1_data_i}
                           : {1'b0, in0_sop_i, in0_eop_i, in0_empty_i, in0_data_i};

    // Next state, round-robin pointer and counters
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        case (state_q)
            IDLE: begin
                if (push0) begin
                    rr_last_d = 1'b0;
                    if (!in0_eop_i) state_d = LOCK0;
                end else if (push1) begin
                    rr_last_d = 1'b1;
                    if (!in1_eop_i) state_d = LOCK1;
                end
            end
            LOCK0:   if (push0 && in0_eop_i) state_d = IDLE;
            LOCK1:   if (push1 && in1_eop_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        pkt0_d = pkt0_q + {{(CW-1){1'b0}}, push0 & in0_eop_i};
        pkt1_d = pkt1_q + {{(CW-1){1'b0}}, push1 & in1_eop_i};
        err_d  = err_q + {{(CW-1){1'b0}}, err0} + {{(CW-1){1'b0}}, err1};
    end

    // Arbiter FSM and statistics registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            run_q     <= 1'b0;
            pkt0_q    <= '0;
            pkt1_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            run_q     <= 1'b1;
            pkt0_q    <= pkt0_d;
            pkt1_q    <= pkt1_d;
            err_q     <= err_d;
        end
    end

    avlstrm_skid_buf #(
        .W (PW)
    ) u_skid (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .in_valid_i    (push0 | push1),
        .in_ready_o    (free),
        .in_payload_i  (skid_in),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_payload_o (skid_out)
    );

    assign out_src_o    = skid_out[PW-1];
    assign out_sop_o    = skid_out[PW-2];
    assign out_eop_o    = skid_out[PW-3];
    assign out_empty_o  = skid_out[DW +: EW];
    assign out_data_o   = skid_out[DW-1:0];
    assign stats_pkt0_o = pkt0_q;
    assign stats_pkt1_o = pkt1_q;
    assign stats_err_o  = err_q;

`ifdef NF_MERGE_STALL_CNT_EN
    logic [CW-1:0] stall_q;
    logic          stall_hit;

    assign stall_hit = ((state_q == LOCK0) && !in0_valid_i) ||
                       ((state_q == LOCK1) && !in1_valid_i);

    // Count cycles where the locked input starves mid-packet
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) stall_q <= '0;
        else        stall_q <= stall_q + {{(CW-1){1'b0}}, stall_hit};
    end

    assign stats_stall_o = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nf_out_merge_avlstrm.sv
// ============================================================================
// tb_nf_out_merge_avlstrm
// Self-checking bench for nf_out_merge_avlstrm: per-source expected-beat
// queues, round-robin tie model, latency/throughput and statistics checks.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_nf_out_merge_avlstrm;

    localparam int DW  = 512;
    localparam int CW  = 32;
    localparam int EW  = $clog2(DW / 8);
    localparam int CKW = 576;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        logic [DW-1:0] data;
    } beat_t;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic [DW-1:0] in0_data_i = '0, in1_data_i = '0;
    logic          in0_valid_i = 1'b0, in1_valid_i = 1'b0;
    logic          in0_sop_i = 1'b0, in1_sop_i = 1'b0;
    logic          in0_eop_i = 1'b0, in1_eop_i = 1'b0;
    logic [EW-1:0] in0_empty_i = '0, in1_empty_i = '0;
    logic          in0_ready_o, in1_ready_o;
    logic [DW-1:0] out_data_o;
    logic          out_valid_o, out_sop_o, out_eop_o, out_src_o;
    logic [EW-1:0] out_empty_o;
    logic          out_ready_i = 1'b1;
    logic [CW-1:0] stats_pkt0_o, stats_pkt1_o, stats_err_o;
`ifdef NF_MERGE_STALL_CNT_EN
    logic [CW-1:0] stats_stall_o;
`endif

    always #5 Clk = ~Clk;

    nf_out_merge_avlstrm #(.DW(DW), .CW(CW)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .in0_data_i   (in0_data_i),
        .in0_valid_i  (in0_valid_i),
        .in0_ready_o  (in0_ready_o),
        .in0_sop_i    (in0_sop_i),
        .in0_eop_i    (in0_eop_i),
        .in0_empty_i  (in0_empty_i),
        .in1_data_i   (in1_data_i),
        .in1_valid_i  (in1_valid_i),
        .in1_ready_o  (in1_ready_o),
        .in1_sop_i    (in1_sop_i),
        .in1_eop_i    (in1_eop_i),
        .in1_empty_i  (in1_empty_i),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_sop_o    (out_sop_o),
        .out_eop_o    (out_eop_o),
        .out_empty_o  (out_empty_o),
        .out_src_o    (out_src_o),
        .stats_pkt0_o (stats_pkt0_o),
        .stats_pkt1_o (stats_pkt1_o),
        .stats_err_o  (stats_err_o)
`ifdef NF_MERGE_STALL_CNT_EN
        ,
        .stats_stall_o(stats_stall_o)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [CKW-1:0] obs, input logic [CKW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    beat_t exp_q0[$];
    beat_t exp_q1[$];
    int    lat_q[$];
    bit    src_q[$];
    int    fire_q[$];
    bit    lat_en  = 1'b0;
    bit    sb_en   = 1'b1;
    bit    rnd_rdy = 1'b0;
    int    cyc     = 0;
    int    out_cnt = 0;
    bit    prev_eop = 1'b1;
    bit    prev_src = 1'b0;

    // Output ready generator: random 50% duty when enabled, else held high
    initial forever begin
        @(posedge Clk);
        #1;
        out_ready_i = rnd_rdy ? 1'($urandom_range(1)) : 1'b1;
    end

    // Output monitor and scoreboard, sampled on the falling edge
    always @(negedge Clk) begin : mon
        beat_t b;
        beat_t e;
        cyc <= cyc + 1;
        if (!Rst_n) begin
            prev_eop <= 1'b1;
        end else if (out_valid_o && out_ready_i) begin
            b = '{sop: out_sop_o, eop: out_eop_o, empty: out_empty_o, data: out_data_o};
            out_cnt <= out_cnt + 1;
            fire_q.push_back(cyc);
            if (out_sop_o) src_q.push_back(out_src_o);
            if (sb_en) begin
                if (!prev_eop) check_val("no_interleave", CKW'(out_src_o), CKW'(prev_src));
                if (out_src_o) begin
                    if (exp_q1.size() == 0) check_val("sb_depth1", CKW'(exp_q1.size()), CKW'(1));
                    else begin e = exp_q1.pop_front(); check_val("sb_beat1", CKW'(b), CKW'(e)); end
                end else begin
                    if (exp_q0.size() == 0) check_val("sb_depth0", CKW'(exp_q0.size()), CKW'(1));
                    else begin e = exp_q0.pop_front(); check_val("sb_beat0", CKW'(b), CKW'(e)); end
                end
            end
            if (lat_en && lat_q.size() != 0)
                check_val("latency", CKW'(cyc - lat_q.pop_front()), CKW'(1));
            prev_eop <= out_eop_o;
            prev_src <= out_src_o;
        end
        if (Rst_n && lat_en && ((in0_valid_i && in0_ready_o) || (in1_valid_i && in1_ready_o)))
            lat_q.push_back(cyc);
    end

    function automatic beat_t mk_beat(input bit sop, input bit eop);
        beat_t b;
        for (int i = 0; i < DW / 32; i++) b.data[i*32 +: 32] = $urandom;
        b.sop   = sop;
        b.eop   = eop;
        b.empty = eop ? EW'($urandom) : '0;
        return b;
    endfunction

    task automatic drive(input bit s, input beat_t b, input bit v);
        if (s) begin
            in1_valid_i = v; in1_sop_i = b.sop; in1_eop_i = b.eop;
            in1_empty_i = b.empty; in1_data_i = b.data;
        end else begin
            in0_valid_i = v; in0_sop_i = b.sop; in0_eop_i = b.eop;
            in0_empty_i = b.empty; in0_data_i = b.data;
        end
    endtask

    // Present one beat and hold it until accepted (bounded)
    task automatic send_beat(input bit s, input beat_t b);
        int n;
        bit rdy;
        n   = 0;
        rdy = 1'b0;
        drive(s, b, 1'b1);
        do begin
            @(negedge Clk);
            rdy = s ? in1_ready_o : in0_ready_o;
            n++;
        end while (!rdy && n < 5000);
        if (!rdy) check_val("accept_timeout", CKW'(rdy), CKW'(1));
        @(posedge Clk);
        #1;
        drive(s, b, 1'b0);
    endtask

    task automatic send_pkt(input bit s, input int len, input bit gaps);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b = mk_beat(i == 0, i == len - 1);
            if (s) exp_q1.push_back(b);
            else   exp_q0.push_back(b);
            send_beat(s, b);
            if (gaps && $urandom_range(3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge Clk);
                #1;
            end
        end
    endtask

    task automatic do_reset();
        #2;
        Rst_n = 1'b0;
        in0_valid_i = 1'b0;
        in1_valid_i = 1'b0;
        repeat (3) @(posedge Clk);
        exp_q0.delete(); exp_q1.delete(); lat_q.delete();
        src_q.delete();  fire_q.delete();
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        repeat (3) @(posedge Clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  base;
        int  n0;
        int  idx;
        int  w;
        bit  last_m;
        bit  win;
        beat_t b;

        // ---- reset state, with a sop beat pending on in0 ----
        in0_valid_i = 1'b1;
        in0_sop_i   = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check_val("rst_out_valid", CKW'(out_valid_o), CKW'(0));
        check_val("rst_in0_ready", CKW'(in0_ready_o), CKW'(0));
        check_val("rst_in1_ready", CKW'(in1_ready_o), CKW'(0));
        check_val("rst_out_src",   CKW'(out_src_o),   CKW'(0));
        check_val("rst_pkt0",      CKW'(stats_pkt0_o), CKW'(0));
        check_val("rst_pkt1",      CKW'(stats_pkt1_o), CKW'(0));
        check_val("rst_err",       CKW'(stats_err_o),  CKW'(0));
        in0_valid_i = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        // ---- 1: single 4-beat packet on in0 ----
        lat_en = 1'b1;
        base   = out_cnt;
        send_pkt(1'b0, 4, 1'b0);
        settle();
        check_val("t1_beats", CKW'(out_cnt - base), CKW'(4));
        check_val("t1_pkt0",  CKW'(stats_pkt0_o), CKW'(1));
        check_val("t1_pkt1",  CKW'(stats_pkt1_o), CKW'(0));
        check_val("t1_left",  CKW'(exp_q0.size()), CKW'(0));

        // ---- 2: simultaneous sop ties, round-robin model ----
        do_reset();
        last_m = 1'b1;
        for (int r = 0; r < 4; r++) begin
            src_q.delete();
            idx = r % 2;
            if (idx == 1) begin
                send_pkt(1'b0, 1, 1'b0);
                last_m = 1'b0;
            end
            fork
                send_pkt(1'b0, 3, 1'b0);
                send_pkt(1'b1, 2, 1'b0);
            join
            settle();
            win = !last_m;
            check_val("t2_sop_count", CKW'(src_q.size()), CKW'(idx + 2));
            if (src_q.size() == idx + 2) begin
                check_val("t2_tie_winner", CKW'(src_q[idx]), CKW'(win));
                check_val("t2_tie_second", CKW'(src_q[idx + 1]), CKW'(!win));
            end
            last_m = !win;
        end
        check_val("t2_left", CKW'(exp_q0.size() + exp_q1.size()), CKW'(0));

        // ---- 3: continuous single-beat packets on both inputs ----
        do_reset();
        fork
            repeat (50) send_pkt(1'b0, 1, 1'b0);
            repeat (50) send_pkt(1'b1, 1, 1'b0);
        join
        settle();
        check_val("t3_count", CKW'(src_q.size()), CKW'(100));
        if (src_q.size() == 100) begin
            for (int i = 0; i < 100; i++) check_val("t3_alternate", CKW'(src_q[i]), CKW'(i % 2));
            check_val("t3_throughput", CKW'(fire_q[99] - fire_q[0]), CKW'(99));
        end
        check_val("t3_pkt0", CKW'(stats_pkt0_o), CKW'(50));
        check_val("t3_pkt1", CKW'(stats_pkt1_o), CKW'(50));
        lat_en = 1'b0;

        // ---- 4: random traffic with random back-pressure ----
        do_reset();
        rnd_rdy = 1'b1;
        n0 = $urandom_range(300, 700);
        fork
            for (int i = 0; i < n0; i++) send_pkt(1'b0, $urandom_range(1, 20), 1'b1);
            for (int i = 0; i < 1000 - n0; i++) send_pkt(1'b1, $urandom_range(1, 20), 1'b1);
        join
        rnd_rdy = 1'b0;
        w = 0;
        while ((exp_q0.size() + exp_q1.size()) != 0 && w < 200) begin
            @(posedge Clk);
            w++;
        end
        settle();
        check_val("t4_left0", CKW'(exp_q0.size()), CKW'(0));
        check_val("t4_left1", CKW'(exp_q1.size()), CKW'(0));
        check_val("t4_sum",   CKW'(stats_pkt0_o + stats_pkt1_o), CKW'(1000));
        check_val("t4_pkt0",  CKW'(stats_pkt0_o), CKW'(n0));
        check_val("t4_err",   CKW'(stats_err_o), CKW'(0));

        // ---- 5: beat without sop on in1 while idle ----
        do_reset();
        base = out_cnt;
        send_beat(1'b1, mk_beat(1'b0, 1'b1));
        settle();
        check_val("t5_err",      CKW'(stats_err_o), CKW'(1));
        check_val("t5_no_out",   CKW'(out_cnt - base), CKW'(0));
        check_val("t5_pkt1_pre", CKW'(stats_pkt1_o), CKW'(0));
        send_pkt(1'b1, 2, 1'b0);
        settle();
        check_val("t5_pkt1",  CKW'(stats_pkt1_o), CKW'(1));
        check_val("t5_err2",  CKW'(stats_err_o), CKW'(1));
        check_val("t5_left",  CKW'(exp_q1.size()), CKW'(0));

        // ---- 6: reset in the middle of a 6-beat packet ----
        do_reset();
        sb_en = 1'b0;
        send_beat(1'b0, mk_beat(1'b1, 1'b0));
        send_beat(1'b0, mk_beat(1'b0, 1'b0));
        send_beat(1'b0, mk_beat(1'b0, 1'b0));
        check_val("t6_pre_valid", CKW'(out_valid_o), CKW'(1));
        b = mk_beat(1'b0, 1'b0);
        drive(1'b0, b, 1'b1);
        #2;
        Rst_n = 1'b0;
        #1;
        check_val("t6_rst_valid",  CKW'(out_valid_o), CKW'(0));
        check_val("t6_rst_ready0", CKW'(in0_ready_o), CKW'(0));
        check_val("t6_rst_ready1", CKW'(in1_ready_o), CKW'(0));
        check_val("t6_rst_src",    CKW'(out_src_o),   CKW'(0));
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        base = out_cnt;
        send_beat(1'b0, b);
        send_beat(1'b0, mk_beat(1'b0, 1'b0));
        send_beat(1'b0, mk_beat(1'b0, 1'b1));
        settle();
        check_val("t6_err",    CKW'(stats_err_o), CKW'(3));
        check_val("t6_no_out", CKW'(out_cnt - base), CKW'(0));
        check_val("t6_pkt0",   CKW'(stats_pkt0_o), CKW'(0));
        sb_en = 1'b1;

`ifdef NF_MERGE_STALL_CNT_EN
        // ---- 7: 5-cycle mid-packet gap on in0 ----
        do_reset();
        b = mk_beat(1'b1, 1'b0);
        exp_q0.push_back(b);
        send_beat(1'b0, b);
        repeat (5) @(posedge Clk);
        #1;
        b = mk_beat(1'b0, 1'b0);
        exp_q0.push_back(b);
        send_beat(1'b0, b);
        b = mk_beat(1'b0, 1'b1);
        exp_q0.push_back(b);
        send_beat(1'b0, b);
        settle();
        check_val("t7_stall", CKW'(stats_stall_o), CKW'(5));
        check_val("t7_left",  CKW'(exp_q0.size()), CKW'(0));
        check_val("t7_pkt0",  CKW'(stats_pkt0_o), CKW'(1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nf_out_merge_avlstrm.md
Name: nf_out_merge_avlstrm

Overview:
Packet-atomic 2:1 merge of the two 512-bit packet streams leaving the non-fast-pattern service: the no-check stream and the checked stream from the bypass-back stage. It produces one packet stream toward the DMA/host egress, with a source tag and per-input statistics counters. The block sits directly downstream of the non-fast-pattern service.

Parameters:
- DW, 512, packet data width in bits; the empty field is $clog2(DW/8) bits.
- CW, 32, width of the statistics counters.

Ports:
- Clk  in  1  core clock
- Rst_n  in  1  reset, asynchronous assert, active-low; one clock, async active-low reset (Clk/Rst_n)
- in0  avl_stream_if.rx  DW  no-check packet stream (data, valid, ready, sop, eop, empty)
- in1  avl_stream_if.rx  DW  checked packet stream, same fields
- out  avl_stream_if.tx  DW  merged packet stream
- out_src  out  1  source of the current out beat (0 = in0, 1 = in1); qualified by out.valid
- stats_pkt0  out  CW  packets (eop beats) forwarded from in0
- stats_pkt1  out  CW  packets forwarded from in1
- stats_err  out  CW  beats dropped because of a framing error

Behaviour:
- Reset values: out.valid=0, in0.ready=0, in1.ready=0, out_src=0, all stats=0. The FSM resets to IDLE and rr_last resets to 1, so in0 wins the first tie.
- Output is registered through a 2-entry skid buffer.
  - out.valid never depends combinationally on out.ready.
  - Latency from input accept to out.valid is 1 cycle.
  - Full throughput is 1 beat/cycle.
- Input ready: inX.ready=1 only when X is granted (or can be granted this cycle) and the skid buffer has at least one free entry.
- FSM states: IDLE, LOCK0, LOCK1.
- IDLE:
  - Candidates are inputs with valid & sop.
  - If both are candidates, grant !rr_last. If one is a candidate, grant it.
  - On the accepted sop beat, set rr_last to the granted input.
  - If that beat is also eop, stay in IDLE. Otherwise go to LOCKX.
- LOCKX:
  - Only inX may be accepted; the other input's ready=0.
  - On the accepted eop beat, return to IDLE.
  - No timeout: a mid-packet stall holds the lock indefinitely.
- Framing errors:
  - A valid beat without sop in IDLE is a framing error. It is accepted (ready=1), dropped, and stats_err increments.
  - A sop beat arriving while in LOCKX on inX is forwarded unchanged and the lock continues. The no-recovery policy belongs upstream.
- Counters:
  - stats_pktX increments on each eop beat of inX written into the skid buffer.
  - Counters wrap modulo 2^CW with no saturation.
  - Simultaneous increments to different counters are independent.
- Back-pressure: out.ready=0 for any duration loses no beats. The skid buffer absorbs the single beat already in flight.
- Reset mid-packet: the FSM returns to IDLE, the buffer is flushed, and counters are cleared. A residual tail arriving without sop is then counted as a framing error.
- Beat order within a packet is preserved. Packets from the two inputs are never interleaved.

Optional Feature:
- Macro: NF_MERGE_STALL_CNT_EN.
- When defined:
  - Adds output port stats_stall (CW bits, reset 0).
  - It counts cycles in LOCK0/LOCK1 where the locked input has valid=0 (mid-packet starvation) and wraps modulo 2^CW.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package (struct_s):
  - typedef merge_state_t {IDLE, LOCK0, LOCK1}
  - stats register address constants REG_NF_MERGE_PKT0, REG_NF_MERGE_PKT1, REG_NF_MERGE_ERR, REG_NF_MERGE_STALL, so that a stats_packer_avlstrm instance at the parent level can export the counters.
- One sub-module, avlstrm_skid_buf: 2-entry registered buffer carrying data, sop, eop, empty and src.

Test Plan:
1. Single 4-beat packet on in0 only, out.ready=1:
   - Beats appear on out 1 cycle after each accept.
   - out_src=0, stats_pkt0=1, stats_pkt1=0.
2. Both inputs present sop in the same cycle after reset; in0 carries 3 beats, in1 carries 2 beats:
   - Output is in0's 3 beats, then in1's 2 beats, with no interleave.
   - The next tie grants in0 again (rr alternation verified over 4 ties).
3. Single-beat packets (sop=eop=1) continuously on both inputs:
   - Output alternates 0,1,0,1 at 1 beat/cycle.
   - After 100 cycles, stats_pkt0=50 and stats_pkt1=50.
4. Random out.ready with 50% duty, 1000 random packets of 1–20 beats:
   - Output matches scoreboard per source.
   - No beat lost or duplicated.
   - Sum of stats_pkt0 and stats_pkt1 equals 1000.
5. Beat without sop on in1 while IDLE:
   - Beat is dropped, stats_err=1, nothing appears on out.
   - The next valid sop packet passes normally.
6. Rst_n asserted in the middle of a 6-beat packet:
   - Outputs are 0 immediately (asynchronous).
   - After release, the remaining tail beats each increment stats_err.
   - With NF_MERGE_STALL_CNT_EN, a 5-cycle in0 gap mid-packet gives stats_stall=5.
